// File: rtl/keygen_pkg.sv
// Shared types and constants for the keygen datapath (coefficient width, default modulus).
package keygen_pkg;

   localparam int unsigned COEF_W = 24;
   localparam logic [COEF_W-1:0] Q_DILITHIUM = 24'd8380417;

   typedef logic [COEF_W-1:0] coef_t;

endpackage

// File: rtl/mod_reduce_once.sv
// Single conditional subtraction: maps sum in [0, 2q) to [0, q).
// Also intended as the final correction step of the modular multiplier.
module mod_reduce_once
   import keygen_pkg::*;
#(
   parameter int unsigned WIDTH = COEF_W
) (
   input  logic [WIDTH:0]   i_sum,
   input  logic [WIDTH-1:0] i_q,
   output logic [WIDTH-1:0] o_res
);

   logic w_ge_q;

   assign w_ge_q = (i_sum >= {1'b0, i_q});
   // Only the low bits of the difference are needed; wraparound in WIDTH bits is exact.
   assign o_res  = w_ge_q ? (i_sum[WIDTH-1:0] - i_q) : i_sum[WIDTH-1:0];

endmodule

// File: rtl/mod_add_pipe.sv
// Two-stage streaming modular adder, res = (a + b) mod q, valid/ready on both sides.
// Optional range_err output enabled by defining MOD_ADD_PIPE_RANGE_CHK_EN.
module mod_add_pipe
   import keygen_pkg::*;
#(
   parameter int unsigned WIDTH = COEF_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] q,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef MOD_ADD_PIPE_RANGE_CHK_EN
   output logic             range_err,
`endif
   output logic [WIDTH-1:0] res
);

   logic             r_s1_valid;
   logic [WIDTH:0]   r_s1_sum;
   logic [WIDTH-1:0] r_s1_q;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_res;
   logic             w_s2_free;
   logic             w_s1_free;
   logic [WIDTH-1:0] w_red;

   // in_ready depends combinationally on out_ready so a full pipe can still
   // accept a beat in the same cycle it drains one.
   assign w_s2_free = !r_out_valid || out_ready;
   assign w_s1_free = !r_s1_valid || w_s2_free;
   assign in_ready  = w_s1_free;
   assign out_valid = r_out_valid;
   assign res       = r_res;

   mod_reduce_once #(
      .WIDTH (WIDTH)
   ) u_reduce (
      .i_sum (r_s1_sum),
      .i_q   (r_s1_q),
      .o_res (w_red)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid  <= 1'b0;
         r_s1_sum    <= '0;
         r_s1_q      <= '0;
         r_out_valid <= 1'b0;
         r_res       <= '0;
      end else begin
         if (w_s1_free) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
               r_s1_sum <= {1'b0, a} + {1'b0, b};
               r_s1_q   <= q;
            end
         end
         if (w_s2_free) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_res <= w_red;
            end
         end
      end
   end

`ifdef MOD_ADD_PIPE_RANGE_CHK_EN
   logic r_s1_err;
   logic r_err;

   assign range_err = r_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_err <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         if (w_s1_free && in_valid) begin
            r_s1_err <= (a >= q) || (b >= q);
         end
         if (w_s2_free && r_s1_valid) begin
            r_err <= r_s1_err;
         end
      end
   end
`endif

endmodule

// File: doc/mod_add_pipe.md
Name: mod_add_pipe

Overview:
- Streaming modular adder: res = (a + b) mod q, for operands already reduced (a, b < q).
- Counterpart to the combinational modular subtractor in the keygen datapath.
- Two-stage pipeline with valid/ready handshakes on both sides, for polynomial coefficient streams between NTT/sampler stages.
- Full throughput: one result per cycle when downstream is ready.

Parameters:
- WIDTH, 24, coefficient and modulus bit width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept an operand beat this cycle.
- a  in  WIDTH  operand A; requires a < q.
- b  in  WIDTH  operand B; requires b < q.
- q  in  WIDTH  modulus; sampled with each beat; requires 2 <= q < 2^WIDTH.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result beat.
- res  out  WIDTH  (a + b) mod q.

Behaviour:
- Reset values: out_valid=0, res=0, stage-1 valid=0, stage-1 sum=0, stage-1 q=0. in_ready=1 in the first cycle after reset.
- Reset mid-operation: all in-flight beats are dropped. No partial output appears.
- Handshake:
  - A beat transfers on a clk edge where valid && ready.
  - A producer holds valid/data stable until the transfer.
  - out_valid never drops and res never changes while out_valid && !out_ready.
- Stage 1 (S1): register sum = a + b at WIDTH+1 bits (no overflow loss), plus q and s1_valid.
- Stage 2 (S2):
  - If sum >= {1'b0,q}, then res = sum - q (low WIDTH bits); otherwise res = sum[WIDTH-1:0].
  - Register res and out_valid.
- Advance rules:
  - s2_free = !out_valid || out_ready.
  - s1_free = !s1_valid || s2_free.
  - in_ready = s1_free. This is a combinational path from out_ready; accepted and documented.
- Latency: 2 cycles from the input transfer edge to out_valid=1, with no stall.
- Throughput: 1 beat/cycle. A simultaneous input accept and output drain in the same cycle is lossless.
- Backpressure: with out_ready=0, at most 2 beats are held; then in_ready=0.
- Ordering: strict FIFO; no reordering.
- Boundary values:
  - a + b = q gives 0.
  - a + b = 2q-2 (max) gives q-2.
  - a = b = 0 gives 0.
- Out-of-range operands (a >= q or b >= q): the result is deterministic per the formula above but not guaranteed < q. No other side effect.
- q changing between beats is legal; each beat uses its own sampled q.

Optional Feature:
- Macro: MOD_ADD_PIPE_RANGE_CHK_EN.
- With the macro defined:
  - Extra output port range_err (1 bit), aligned with res and qualified by out_valid.
  - range_err = 1 when that beat had a >= q or b >= q.
  - Carried through S1/S2 like data; reset value 0.
  - Held stable under stall like res.
- Without the macro: port and logic absent; the datapath is otherwise identical.

Decomposition:
- Shared package keygen_pkg:
  - COEF_W = 24.
  - Q_DILITHIUM = 24'd8380417 (default modulus for benches).
  - typedef coef_t (logic [COEF_W-1:0]).
- One natural sub-module: mod_reduce_once. Combinational: input sum (WIDTH+1) and q, output the conditionally subtracted value. Instantiated in S2 and reusable by future modular-multiplier final correction.

Test Plan (q = 8380417 unless stated):
- Simple: a=5, b=7, out_ready=1 -> res=12, out_valid exactly 2 cycles after the accept.
- Wrap: a=8380416, b=1 -> res=0; a=8380416, b=8380416 -> res=8380415; a=0, b=0 -> res=0.
- Streaming: 1000 random in-range beats, in_valid=1, out_ready=1 -> 1 result/cycle, all match reference (a+b)%q, in order.
- Backpressure: out_ready=0 for 5 cycles while feeding 3 beats -> in_ready=0 after 2 accepted; res stable; after release, 3 results in order, none lost or duplicated.
- Reset mid-stream: assert rst for 1 cycle with 2 beats in flight -> out_valid=0 next cycle, no stale beats emitted; new beat a=1, b=2 -> res=3.
- Macro on: a=8380417, b=0 -> range_err=1; a=3, b=4, q=7 -> res=0, range_err=0.
